// File: rtl/fp_sign_pipe_pkg.sv
// Shared codes and field-position helpers for the FP sign-resolution pipe.
// Pure declarations; no state, no latency.
// No handshake here; consumers apply their own flow control.
package fp_sign_pipe_pkg;

    // Default single-precision field widths
    localparam int EXP_W_DEF = 8;
    localparam int MAN_W_DEF = 23;

    // Operation mode codes; code 3 is reserved and behaves as ADD/SUB
    localparam logic [1:0] MODE_ADDSUB = 2'd0;
    localparam logic [1:0] MODE_MUL    = 2'd1;
    localparam logic [1:0] MODE_DIV    = 2'd2;

    // Rounding mode codes
    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    // Operand layout is {sign, exponent, mantissa}
    function automatic int sign_pos(input int exp_w, input int man_w);
        return exp_w + man_w;
    endfunction

    function automatic int exp_msb(input int exp_w, input int man_w);
        return exp_w + man_w - 1;
    endfunction

    function automatic int exp_lsb(input int man_w);
        return man_w;
    endfunction

    // MUL and DIV share the sign rule; everything else is treated as ADD/SUB
    function automatic logic is_muldiv(input logic [1:0] mode);
        return (mode == MODE_MUL) || (mode == MODE_DIV);
    endfunction

endpackage

// File: rtl/fp_sign_pipe_if.sv
// Operand/result bundle for fp_sign_pipe with valid/ready on both sides.
// Wires only; latency is defined by the connected unit.
// master drives operands and out_ready; slave (the unit) drives in_ready and results.
interface fp_sign_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int OP_W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  operand_x;
    logic [OP_W-1:0]  operand_y;
    logic             op_sub;
    logic [1:0]       mode;
    logic [2:0]       round_mode;
    logic             out_valid;
    logic             out_ready;
    logic             res_sign;
    logic             eff_sub;
    logic             swap;
    logic [EXP_W-1:0] exp_diff;
    logic             zero_result;

    modport master (
        output in_valid, operand_x, operand_y, op_sub, mode, round_mode, out_ready,
        input  in_ready, out_valid, res_sign, eff_sub, swap, exp_diff, zero_result
    );

    modport slave (
        input  in_valid, operand_x, operand_y, op_sub, mode, round_mode, out_ready,
        output in_ready, out_valid, res_sign, eff_sub, swap, exp_diff, zero_result
    );

endinterface

// File: rtl/fp_sign_pipe_mag_cmp.sv
// Unsigned magnitude comparator: gt = (a > b), eq = (a == b).
// Combinational, zero latency.
// No handshake; the caller decides when the result is used.
module fp_mag_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    logic [W:0] diff;

    // One extra bit catches the borrow; zero low bits means equal operands
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        eq   = (diff[W-1:0] == '0);
        gt   = ~diff[W] & ~eq;
    end

endmodule

// File: rtl/fp_sign_pipe.sv
// Sign resolution for FP add/sub/mul/div: effective op, swap, exponent distance, result sign.
// Two-cycle latency from accept to out_valid; one result per cycle when out_ready stays high.
// Stalls hold both stages; in_ready drops only when both stages are full and out_ready is low.
module fp_sign_pipe
    import fp_sign_pipe_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fp_sign_pipe_if.slave io
);

    localparam int S_POS = sign_pos(EXP_W, MAN_W);
    localparam int E_MSB = exp_msb(EXP_W, MAN_W);
    localparam int E_LSB = exp_lsb(MAN_W);

    // Operand field slices
    logic             sx_in, sy_in;
    logic [EXP_W-1:0] ex_in, ey_in;
    logic [MAN_W-1:0] mx_in, my_in;

    assign sx_in = io.operand_x[S_POS];
    assign sy_in = io.operand_y[S_POS];
    assign ex_in = io.operand_x[E_MSB:E_LSB];
    assign ey_in = io.operand_y[E_MSB:E_LSB];
    assign mx_in = io.operand_x[MAN_W-1:0];
    assign my_in = io.operand_y[MAN_W-1:0];

    // Stage 1 state
    logic             v1_q, v1_d;
    logic             sx_q, sx_d;
    logic             sy_eff_q, sy_eff_d;
    logic             eff_sub1_q, eff_sub1_d;
    logic             md_sign_q, md_sign_d;
    logic             exp_gt_q, exp_gt_d;
    logic             exp_eq_q, exp_eq_d;
    logic [EXP_W-1:0] exp_mag_q, exp_mag_d;
    logic [MAN_W-1:0] man_x_q, man_x_d;
    logic [MAN_W-1:0] man_y_q, man_y_d;
    logic [1:0]       mode_q, mode_d;
    logic [2:0]       rm_q, rm_d;

    // Stage 2 (output) state
    logic             v2_q, v2_d;
    logic             res_sign_q, res_sign_d;
    logic             eff_sub_q, eff_sub_d;
    logic             swap_q, swap_d;
    logic [EXP_W-1:0] exp_diff_q, exp_diff_d;
    logic             zero_q, zero_d;

    logic adv1, adv2;
    logic exp_gt, exp_eq;
    logic man_gt, man_eq;

    fp_mag_cmp #(.W(EXP_W)) u_exp_cmp (
        .a  (ex_in),
        .b  (ey_in),
        .gt (exp_gt),
        .eq (exp_eq)
    );

    fp_mag_cmp #(.W(MAN_W)) u_man_cmp (
        .a  (man_x_q),
        .b  (man_y_q),
        .gt (man_gt),
        .eq (man_eq)
    );

    // A stage may advance when it is empty or its successor advances
    always_comb begin
        adv2 = ~v2_q | io.out_ready;
        adv1 = ~v1_q | adv2;
    end

    assign io.in_ready    = adv1;
    assign io.out_valid   = v2_q;
    assign io.res_sign    = res_sign_q;
    assign io.eff_sub     = eff_sub_q;
    assign io.swap        = swap_q;
    assign io.exp_diff    = exp_diff_q;
    assign io.zero_result = zero_q;

    // Stage 1: exponent subtract/compare, effective operation, field capture
    always_comb begin
        logic [EXP_W:0] exp_sub;
        logic           md;
        logic           sy_eff;

        v1_d       = v1_q;
        sx_d       = sx_q;
        sy_eff_d   = sy_eff_q;
        eff_sub1_d = eff_sub1_q;
        md_sign_d  = md_sign_q;
        exp_gt_d   = exp_gt_q;
        exp_eq_d   = exp_eq_q;
        exp_mag_d  = exp_mag_q;
        man_x_d    = man_x_q;
        man_y_d    = man_y_q;
        mode_d     = mode_q;
        rm_d       = rm_q;

        exp_sub = {1'b0, ex_in} - {1'b0, ey_in};
        md      = is_muldiv(io.mode);
        sy_eff  = sy_in ^ io.op_sub;

        if (adv1) begin
            v1_d = io.in_valid;
            if (io.in_valid) begin
                sx_d       = sx_in;
                sy_eff_d   = md ? 1'b0 : sy_eff;
                eff_sub1_d = md ? 1'b0 : (sx_in ^ sy_eff);
                md_sign_d  = sx_in ^ sy_in;
                exp_gt_d   = exp_gt;
                exp_eq_d   = exp_eq;
                // Borrow set means Ey > Ex: negate to get the magnitude
                exp_mag_d  = exp_sub[EXP_W] ? ('0 - exp_sub[EXP_W-1:0]) : exp_sub[EXP_W-1:0];
                man_x_d    = mx_in;
                man_y_d    = my_in;
                mode_d     = io.mode;
                rm_d       = io.round_mode;
            end
        end
    end

    // Stage 2: mantissa tie-break, swap/cancellation detection, final sign select
    always_comb begin
        logic x_gt, mag_eq, y_gt;

        v2_d       = v2_q;
        res_sign_d = res_sign_q;
        eff_sub_d  = eff_sub_q;
        swap_d     = swap_q;
        exp_diff_d = exp_diff_q;
        zero_d     = zero_q;

        // Mantissa order only matters when exponents tie
        x_gt   = exp_gt_q | (exp_eq_q & man_gt);
        mag_eq = exp_eq_q & man_eq;
        y_gt   = ~x_gt & ~mag_eq;

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                if (is_muldiv(mode_q)) begin
                    res_sign_d = md_sign_q;
                    eff_sub_d  = 1'b0;
                    swap_d     = 1'b0;
                    exp_diff_d = '0;
                    zero_d     = 1'b0;
                end else begin
                    eff_sub_d  = eff_sub1_q;
                    swap_d     = y_gt;
                    exp_diff_d = exp_mag_q;
                    zero_d     = 1'b0;
                    if (!eff_sub1_q || x_gt) begin
                        res_sign_d = sx_q;
                    end else if (y_gt) begin
                        res_sign_d = sy_eff_q;
                    end else begin
                        // Exact cancellation: zero is negative only when rounding down
                        zero_d     = 1'b1;
                        res_sign_d = (rm_q == RM_RDN);
                    end
                end
            end
        end
    end

    // Pipeline registers; reset empties both stages and clears the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q       <= 1'b0;
            sx_q       <= 1'b0;
            sy_eff_q   <= 1'b0;
            eff_sub1_q <= 1'b0;
            md_sign_q  <= 1'b0;
            exp_gt_q   <= 1'b0;
            exp_eq_q   <= 1'b0;
            exp_mag_q  <= '0;
            man_x_q    <= '0;
            man_y_q    <= '0;
            mode_q     <= MODE_ADDSUB;
            rm_q       <= RM_RNE;
            v2_q       <= 1'b0;
            res_sign_q <= 1'b0;
            eff_sub_q  <= 1'b0;
            swap_q     <= 1'b0;
            exp_diff_q <= '0;
            zero_q     <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            sx_q       <= sx_d;
            sy_eff_q   <= sy_eff_d;
            eff_sub1_q <= eff_sub1_d;
            md_sign_q  <= md_sign_d;
            exp_gt_q   <= exp_gt_d;
            exp_eq_q   <= exp_eq_d;
            exp_mag_q  <= exp_mag_d;
            man_x_q    <= man_x_d;
            man_y_q    <= man_y_d;
            mode_q     <= mode_d;
            rm_q       <= rm_d;
            v2_q       <= v2_d;
            res_sign_q <= res_sign_d;
            eff_sub_q  <= eff_sub_d;
            swap_q     <= swap_d;
            exp_diff_q <= exp_diff_d;
            zero_q     <= zero_d;
        end
    end

endmodule

// File: tb/tb_fp_sign_pipe.sv
// Scoreboard bench for fp_sign_pipe: directed vectors, random traffic, backpressure, mid-flight reset.
// Expected results come from a reference model over whole magnitudes.
// Driver and monitor run as separate processes sharing only the expected-result queue.
module tb_fp_sign_pipe;
    import fp_sign_pipe_pkg::*;

    typedef struct packed {
        logic       res;
        logic       eff;
        logic       swap;
        logic [7:0] diff;
        logic       zero;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    res_t sbq[$];
    int   rdy_mode = 0;

    fp_sign_pipe_if #(.EXP_W(8), .MAN_W(23)) io ();

    fp_sign_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signs and magnitudes straight from the operation rules
    function automatic res_t ref_model(input logic [31:0] x, input logic [31:0] y,
                                       input logic op, input logic [1:0] m, input logic [2:0] rm);
        res_t        r;
        int unsigned mx, my;
        int          ex, ey;
        logic        syeff;
        r  = '0;
        mx = {1'b0, x[30:0]};
        my = {1'b0, y[30:0]};
        ex = {24'd0, x[30:23]};
        ey = {24'd0, y[30:23]};
        if (m == MODE_MUL || m == MODE_DIV) begin
            r.res = x[31] ^ y[31];
            return r;
        end
        syeff  = y[31] ^ op;
        r.eff  = (x[31] != syeff);
        r.diff = 8'((ex >= ey) ? (ex - ey) : (ey - ex));
        r.swap = (my > mx);
        if (!r.eff)         r.res = x[31];
        else if (mx > my)   r.res = x[31];
        else if (my > mx)   r.res = syeff;
        else begin
            r.zero = 1'b1;
            r.res  = (rm == RM_RDN);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(io.out_valid), 32'd0);
        chk({tag, "_in_ready"},  32'(io.in_ready), 32'd1);
        chk({tag, "_res_sign"},  32'(io.res_sign), 32'd0);
        chk({tag, "_eff_sub"},   32'(io.eff_sub), 32'd0);
        chk({tag, "_swap"},      32'(io.swap), 32'd0);
        chk({tag, "_exp_diff"},  32'(io.exp_diff), 32'd0);
        chk({tag, "_zero"},      32'(io.zero_result), 32'd0);
    endtask

    // Advance to the next falling edge and set out_ready for the coming cycle
    task automatic step();
        @(negedge clk);
        case (rdy_mode)
            0:       io.out_ready = 1'b1;
            1:       io.out_ready = ($urandom_range(0, 3) != 0);
            default: io.out_ready = 1'b0;
        endcase
    endtask

    task automatic idle(input int n);
        io.in_valid = 1'b0;
        repeat (n) step();
    endtask

    // Present one operand pair until accepted; push the expected result on accept
    task automatic send(input logic [31:0] x, input logic [31:0] y, input logic op,
                        input logic [1:0] m, input logic [2:0] rm, input bit use_k, input res_t k);
        int n = 0;
        io.in_valid   = 1'b1;
        io.operand_x  = x;
        io.operand_y  = y;
        io.op_sub     = op;
        io.mode       = m;
        io.round_mode = rm;
        forever begin
            #1;
            if (io.in_ready) begin
                sbq.push_back(use_k ? k : ref_model(x, y, op, m, rm));
                step();
                break;
            end
            step();
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout actual=no_accept required=accept");
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sbq.size() != 0 && w < 500) begin
            step();
            w++;
        end
        chk({tag, "_drained"}, 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: compare each consumed result, and hold-stability while stalled
    initial begin : monitor
        res_t act, req, held;
        bit   stalled;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                stalled = 1'b0;
                continue;
            end
            act = '{io.res_sign, io.eff_sub, io.swap, io.exp_diff, io.zero_result};
            if (stalled) begin
                chk("stall_valid_held", 32'(io.out_valid), 32'd1);
                chk("stall_data_held", 32'(act), 32'(held));
            end
            if (io.out_valid && io.out_ready) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual=%0h required=no_output", act);
                end else begin
                    req = sbq.pop_front();
                    if (act !== req) begin
                        failures++;
                        $display("FAIL result actual(sign=%0b eff=%0b swap=%0b diff=%0d zero=%0b) required(sign=%0b eff=%0b swap=%0b diff=%0d zero=%0b)",
                                 act.res, act.eff, act.swap, act.diff, act.zero,
                                 req.res, req.eff, req.swap, req.diff, req.zero);
                    end
                end
            end
            stalled = io.out_valid && !io.out_ready;
            held    = act;
        end
    end

    // Driver
    initial begin : driver
        logic [31:0] x, y;
        res_t        none;
        none          = '0;
        rst_n         = 1'b0;
        io.in_valid   = 1'b0;
        io.operand_x  = '0;
        io.operand_y  = '0;
        io.op_sub     = 1'b0;
        io.mode       = MODE_ADDSUB;
        io.round_mode = RM_RNE;
        io.out_ready  = 1'b0;
        #1;
        reset_checks("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Directed vectors with hand-derived results
        send(32'h40400000, 32'h40A00000, 1'b1, MODE_ADDSUB, RM_RNE, 1'b1, '{1'b1, 1'b1, 1'b1, 8'd1, 1'b0});
        send(32'h40000000, 32'h40000000, 1'b1, MODE_ADDSUB, RM_RDN, 1'b1, '{1'b1, 1'b1, 1'b0, 8'd0, 1'b1});
        send(32'h40000000, 32'h40000000, 1'b1, MODE_ADDSUB, RM_RNE, 1'b1, '{1'b0, 1'b1, 1'b0, 8'd0, 1'b1});
        send(32'hBFC00000, 32'h40000000, 1'b0, MODE_MUL,    RM_RNE, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0});
        send(32'hC0E00000, 32'h3F800000, 1'b0, MODE_ADDSUB, RM_RNE, 1'b1, '{1'b1, 1'b1, 1'b0, 8'd2, 1'b0});
        send(32'hC0E00000, 32'h3F800000, 1'b1, MODE_DIV,    RM_RDN, 1'b1, '{1'b1, 1'b0, 1'b0, 8'd0, 1'b0});
        send(32'h3F800000, 32'h40000000, 1'b0, 2'd3,        RM_RUP, 1'b1, '{1'b0, 1'b0, 1'b1, 8'd1, 1'b0});
        send(32'h00000001, 32'h00000002, 1'b1, MODE_ADDSUB, RM_RTZ, 1'b1, '{1'b1, 1'b1, 1'b1, 8'd0, 1'b0});
        idle(2);
        drain("directed");

        // Latency: accepted at one edge, visible after the second
        send(32'h40400000, 32'h40A00000, 1'b0, MODE_ADDSUB, RM_RNE, 1'b0, none);
        io.in_valid = 1'b0;
        #1;
        chk("latency_not_early", 32'(io.out_valid), 32'd0);
        step();
        #1;
        chk("latency_two_cycles", 32'(io.out_valid), 32'd1);
        idle(3);

        // Random traffic with random out_ready
        rdy_mode = 1;
        repeat (300) begin
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 3))
                0: y[30:0]  = x[30:0];
                1: y[30:23] = x[30:23];
                default: ;
            endcase
            send(x, y, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 3'($urandom_range(0, 4)), 1'b0, none);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rdy_mode = 0;
        idle(1);
        drain("random");

        // Backpressure: two accepts fill the pipe, then in_ready must fall
        rdy_mode = 2;
        step();
        send(32'h40400000, 32'h40A00000, 1'b1, MODE_ADDSUB, RM_RNE, 1'b0, none);
        send(32'hC0E00000, 32'h3F800000, 1'b0, MODE_ADDSUB, RM_RNE, 1'b0, none);
        io.in_valid  = 1'b1;
        io.operand_x = 32'h40000000;
        io.operand_y = 32'h40000000;
        io.op_sub    = 1'b1;
        io.mode      = MODE_ADDSUB;
        io.round_mode = RM_RDN;
        #1;
        chk("full_in_ready_low", 32'(io.in_ready), 32'd0);
        chk("full_out_valid", 32'(io.out_valid), 32'd1);
        repeat (3) begin
            step();
            #1;
            chk("stalled_in_ready_low", 32'(io.in_ready), 32'd0);
        end
        @(negedge clk);
        rdy_mode = 0;
        io.out_ready = 1'b1;
        #1;
        chk("release_same_cycle", 32'(io.in_ready), 32'd1);
        send(32'h40000000, 32'h40000000, 1'b1, MODE_ADDSUB, RM_RDN, 1'b0, none);
        send(32'hBFC00000, 32'h40000000, 1'b0, MODE_MUL, RM_RNE, 1'b0, none);
        idle(1);
        drain("backpressure");

        // Reset with both stages full: everything clears, nothing emerges later
        rdy_mode = 2;
        step();
        send(32'h40400000, 32'h40A00000, 1'b1, MODE_ADDSUB, RM_RNE, 1'b0, none);
        send(32'hC0E00000, 32'h3F800000, 1'b0, MODE_ADDSUB, RM_RNE, 1'b0, none);
        io.in_valid = 1'b0;
        #1;
        chk("prereset_full", 32'(io.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        reset_checks("midreset");
        sbq.delete();
        step();
        step();
        rst_n = 1'b1;
        rdy_mode = 0;
        idle(10);
        chk("post_reset_idle", 32'(io.out_valid), 32'd0);
        drain("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_sign_pipe.md
# fp_sign_pipe

Pipelined, handshaked sign-resolution unit for the floating-point datapath. It is the parametrised successor of the combinational add/sub sign stage. From the raw operand fields it computes:
- the effective operation,
- the exponent and magnitude comparison,
- the final result sign for ADD/SUB and MUL/DIV.

It adds IEEE exact-cancellation zero-sign handling that depends on the rounding mode. It sits beside the alignment shifter and feeds sign, swap and shift-amount to the mantissa adder and normaliser.

## Interface
- EXP_W, 8: exponent field width
- MAN_W, 23: stored mantissa field width (no hidden bit)
- Clk  in  1  clock, all state on rising edge
- RstN  in  1  asynchronous active-low reset
- InValid  in  1  operand pair present
- InReady  out  1  unit accepts operands this cycle
- OperandX  in  1+EXP_W+MAN_W  {sign, exponent, mantissa}
- OperandY  in  1+EXP_W+MAN_W  same layout
- OpSub  in  1  1 = X−Y, 0 = X+Y (ignored in MUL/DIV)
- Mode  in  2  0 ADD/SUB, 1 MUL, 2 DIV, 3 reserved (treated as ADD/SUB)
- RoundMode  in  3  0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
- OutValid  out  1  result present
- OutReady  in  1  downstream consumes result
- ResSign  out  1  final result sign
- EffSub  out  1  effective subtraction performed (ADD/SUB only)
- Swap  out  1  |Y| > |X|; downstream uses Y as the larger operand
- ExpDiff  out  EXP_W  |Ex − Ey|
- ZeroResult  out  1  exact cancellation: EffSub and |X| == |Y|

## Operation
- Effective Y sign: SyEff = Sy ^ OpSub. EffSub = Sx ^ SyEff. Both are forced to 0 in MUL/DIV.
- MUL/DIV: ResSign = Sx ^ Sy; Swap, ExpDiff and ZeroResult are 0.
- ADD/SUB, EffSub = 0: ResSign = Sx. Swap and ExpDiff are still computed.
- ADD/SUB, EffSub = 1:
  - |X| > |Y| → ResSign = Sx.
  - |Y| > |X| → ResSign = SyEff, Swap = 1.
  - Equal → ZeroResult = 1, ResSign = (RoundMode == RDN), Swap = 0.
- Magnitude compare is unsigned over {exponent, mantissa}, so denormals compare correctly.
- Exponent difference uses an EXP_W+1 bit subtractor. The borrow gives ExpGtY / ExpLtX; the zero flag gives ExpEq. The magnitude is taken by conditional negate.
- NaN/Inf are not detected here. The special-case unit overrides the result downstream. Fields pass through arithmetic unchanged.

## Timing
- Two-stage pipeline, latency 2 cycles from InValid&InReady to OutValid. Throughput 1 per cycle when OutReady is held high.
- Stage 1 (registered inputs):
  - exponent subtract, ExpEq/ExpGt, ExpDiff magnitude
  - SyEff and EffSub
  - mantissa fields, Mode and RoundMode carried forward
- Stage 2: mantissa compare (used only when ExpEq), Swap/ZeroResult/ResSign select. The output register holds the results.
- Handshake:
  - Each stage holds a valid bit. Advance2 = ~V2 | OutReady; Advance1 = ~V1 | Advance2.
  - InReady = Advance1 (combinational from OutReady, no combinational path from InValid).
  - While OutValid = 1 and OutReady = 0, all outputs are stable.
  - No transaction is dropped or duplicated; order is preserved.
- Full: with V1 = V2 = 1 and OutReady = 0, InReady = 0. A simultaneous OutReady = 1 releases InReady in the same cycle.
- Reset (async assert, sync-clean deassert by the system):
  - V1 = V2 = 0, OutValid = 0, ResSign = EffSub = Swap = ZeroResult = 0, ExpDiff = 0.
  - InReady = 1 while reset is asserted.
  - Reset mid-flight discards both stages; no output appears afterwards for pre-reset inputs.

## Structure
- Shared package/include fp_pkg:
  - Mode codes (MODE_ADDSUB, MODE_MUL, MODE_DIV)
  - rounding-mode codes (RNE…RMM)
  - operand field-slicing macros/localparams for sign, exponent and mantissa positions given EXP_W/MAN_W
- One sub-module, fp_mag_cmp: parametrised unsigned comparator returning gt/eq. It is instantiated for the exponent in stage 1 and the mantissa in stage 2.
- Pipeline valid/advance logic stays in the top module.

## Test plan
- Single precision, X=0x40400000 (+3.0), Y=0x40A00000 (+5.0), OpSub=1, RNE → two cycles later ResSign=1, EffSub=1, Swap=1, ExpDiff=1, ZeroResult=0.
- X=Y=0x40000000 (+2.0), OpSub=1, RDN → ResSign=1, ZeroResult=1. Repeat with RNE → ResSign=0, ZeroResult=1.
- Mode=MUL, X=0xBFC00000 (−1.5), Y=0x40000000 (+2.0) → ResSign=1, EffSub=0, Swap=0, ExpDiff=0.
- X=0xC0E00000 (−7.0), Y=0x3F800000 (+1.0), OpSub=0 → EffSub=1, ResSign=1, Swap=0, ExpDiff=2.
- Backpressure: four back-to-back inputs with OutReady=0 → InReady falls after two accepts. Then raise OutReady → four results emerge in order with no loss, outputs stable while stalled.
- Assert RstN low with both stages full → OutValid=0 immediately, all outputs 0, InReady=1. No stale result appears after release.
